// File: rtl/gpio_axil_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite GPIO block.
package gpio_axil_pkg;

    // Register byte offsets
    localparam int unsigned OFF_IDR = 32'h00;
    localparam int unsigned OFF_ODR = 32'h04;
    localparam int unsigned OFF_DIR = 32'h08;
    localparam int unsigned OFF_SET = 32'h0C;
    localparam int unsigned OFF_CLR = 32'h10;
    localparam int unsigned OFF_RIE = 32'h14;
    localparam int unsigned OFF_FIE = 32'h18;
    localparam int unsigned OFF_ISR = 32'h1C;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel states: idle, address/data accepted this cycle, response pending
    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACCEPT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    // Read channel states: idle, address accepted this cycle, data pending
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACCEPT = 2'd1,
        RD_DATA   = 2'd2
    } rd_state_t;

    // Expand 4 byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain plus previous-sample register and edge detection.
module gpio_sync_edge #(
    parameter int unsigned GPIO_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [GPIO_WIDTH-1:0] i_gpio,
    output logic [GPIO_WIDTH-1:0] o_sync,
    output logic [GPIO_WIDTH-1:0] o_rise_c,
    output logic [GPIO_WIDTH-1:0] o_fall_c
);

    logic [GPIO_WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] r_prev;

    // Shift pins through the synchroniser and remember last synchronised value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_chain[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_chain[0] <= i_gpio;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_prev <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync   = r_chain[SYNC_STAGES-1];
    assign o_rise_c = r_chain[SYNC_STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_chain[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/gpio_axil_irq.sv
// AXI4-Lite GPIO with direction control, set/clear, and edge interrupts.
module gpio_axil_irq
    import gpio_axil_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic [31:0]           s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] A_IDR = ADDR_WIDTH'(OFF_IDR);
    localparam logic [ADDR_WIDTH-1:0] A_ODR = ADDR_WIDTH'(OFF_ODR);
    localparam logic [ADDR_WIDTH-1:0] A_DIR = ADDR_WIDTH'(OFF_DIR);
    localparam logic [ADDR_WIDTH-1:0] A_SET = ADDR_WIDTH'(OFF_SET);
    localparam logic [ADDR_WIDTH-1:0] A_CLR = ADDR_WIDTH'(OFF_CLR);
    localparam logic [ADDR_WIDTH-1:0] A_RIE = ADDR_WIDTH'(OFF_RIE);
    localparam logic [ADDR_WIDTH-1:0] A_FIE = ADDR_WIDTH'(OFF_FIE);
    localparam logic [ADDR_WIDTH-1:0] A_ISR = ADDR_WIDTH'(OFF_ISR);
    localparam logic [ADDR_WIDTH-1:0] A_WORD_MASK = ~ADDR_WIDTH'(3);

    // Register file
    logic [GPIO_WIDTH-1:0] r_odr;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_rie;
    logic [GPIO_WIDTH-1:0] r_fie;
    logic [GPIO_WIDTH-1:0] r_isr;

    // AXI channel state and registered outputs
    wr_state_t   r_wr_state, w_wr_state_nxt;
    rd_state_t   r_rd_state, w_rd_state_nxt;
    logic        r_awready, w_awready_nxt;
    logic        r_bvalid,  w_bvalid_nxt;
    logic [1:0]  r_bresp,   w_bresp_nxt;
    logic        r_arready, w_arready_nxt;
    logic        r_rvalid,  w_rvalid_nxt;
    logic [1:0]  r_rresp,   w_rresp_nxt;
    logic [31:0] r_rdata,   w_rdata_nxt;

    // Decode and datapath wires
    logic [ADDR_WIDTH-1:0] w_wr_off;
    logic [ADDR_WIDTH-1:0] w_rd_off;
    logic                  w_wr_mapped;
    logic                  w_rd_mapped;
    logic                  w_wr_fire;
    logic [31:0]           w_mask32;
    logic [GPIO_WIDTH-1:0] w_wmask;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_isr_clr;
    logic [GPIO_WIDTH-1:0] w_isr_set;
    logic [GPIO_WIDTH-1:0] w_sync;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    // Pin synchroniser and edge detector
    gpio_sync_edge #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk    (s_axi_aclk),
        .i_rst    (s_axi_areset),
        .i_gpio   (gpio_in),
        .o_sync   (w_sync),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    assign w_wr_off    = s_axi_awaddr[ADDR_WIDTH-1:0] & A_WORD_MASK;
    assign w_rd_off    = s_axi_araddr[ADDR_WIDTH-1:0] & A_WORD_MASK;
    assign w_wr_mapped = (w_wr_off <= A_ISR);
    assign w_rd_mapped = (w_rd_off <= A_ISR);
    assign w_wr_fire   = r_awready && s_axi_awvalid && s_axi_wvalid && w_wr_mapped;
    assign w_mask32    = strb_mask(s_axi_wstrb);
    assign w_wmask     = w_mask32[GPIO_WIDTH-1:0];
    assign w_wdata     = s_axi_wdata[GPIO_WIDTH-1:0];
    assign w_isr_clr   = (w_wr_fire && (w_wr_off == A_ISR)) ? (w_wdata & w_wmask) : '0;
    assign w_isr_set   = (w_rise & r_rie) | (w_fall & r_fie);

    // Bus bits beyond the decoded address and pin count are intentionally dropped
    assign w_unused = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, w_mask32};

    // Write channel next-state and registered-output values
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_awready_nxt  = 1'b0;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        case (r_wr_state)
            WR_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_wr_state_nxt = WR_ACCEPT;
                    w_awready_nxt  = 1'b1;
                end
            end
            WR_ACCEPT: begin
                w_wr_state_nxt = WR_RESP;
                w_bvalid_nxt   = 1'b1;
                w_bresp_nxt    = w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    w_wr_state_nxt = WR_IDLE;
                    w_bvalid_nxt   = 1'b0;
                end
            end
            default: begin
                w_wr_state_nxt = WR_IDLE;
                w_bvalid_nxt   = 1'b0;
            end
        endcase
    end

    // Read data mux for mapped offsets; write-only registers read as zero
    always_comb begin
        w_rd_val = '0;
        case (w_rd_off)
            A_IDR:   w_rd_val = 32'(w_sync);
            A_ODR:   w_rd_val = 32'(r_odr);
            A_DIR:   w_rd_val = 32'(r_dir);
            A_RIE:   w_rd_val = 32'(r_rie);
            A_FIE:   w_rd_val = 32'(r_fie);
            A_ISR:   w_rd_val = 32'(r_isr);
            default: w_rd_val = '0;
        endcase
    end

    // Read channel next-state and registered-output values
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = 1'b0;
        w_rvalid_nxt   = r_rvalid;
        w_rresp_nxt    = r_rresp;
        w_rdata_nxt    = r_rdata;
        case (r_rd_state)
            RD_IDLE: begin
                if (s_axi_arvalid) begin
                    w_rd_state_nxt = RD_ACCEPT;
                    w_arready_nxt  = 1'b1;
                end
            end
            RD_ACCEPT: begin
                w_rd_state_nxt = RD_DATA;
                w_rvalid_nxt   = 1'b1;
                w_rresp_nxt    = w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
                w_rdata_nxt    = w_rd_mapped ? w_rd_val : '0;
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    w_rd_state_nxt = RD_IDLE;
                    w_rvalid_nxt   = 1'b0;
                end
            end
            default: begin
                w_rd_state_nxt = RD_IDLE;
                w_rvalid_nxt   = 1'b0;
            end
        endcase
    end

    // AXI channel state and handshake registers
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_awready  <= w_awready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    // Register file updates; an edge setting ISR wins over a same-cycle W1C
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_odr <= '0;
            r_dir <= '0;
            r_rie <= '0;
            r_fie <= '0;
            r_isr <= '0;
        end else begin
            if (w_wr_fire) begin
                case (w_wr_off)
                    A_ODR:   r_odr <= (r_odr & ~w_wmask) | (w_wdata & w_wmask);
                    A_DIR:   r_dir <= (r_dir & ~w_wmask) | (w_wdata & w_wmask);
                    A_SET:   r_odr <= r_odr | (w_wdata & w_wmask);
                    A_CLR:   r_odr <= r_odr & ~(w_wdata & w_wmask);
                    A_RIE:   r_rie <= (r_rie & ~w_wmask) | (w_wdata & w_wmask);
                    A_FIE:   r_fie <= (r_fie & ~w_wmask) | (w_wdata & w_wmask);
                    default: ;
                endcase
            end
            r_isr <= (r_isr & ~w_isr_clr) | w_isr_set;
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign gpio_out      = r_odr;
    assign gpio_oe       = r_dir;
    assign irq           = |r_isr;

endmodule

// File: tb/tb_gpio_axil_irq.sv
// Directed self-checking bench for gpio_axil_irq (16 pins, 2 sync stages).
module tb_gpio_axil_irq;

    localparam int unsigned W = 16;

    logic        clk;
    logic        areset;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic        irq;

    int n_checks;
    int n_errors;

    logic [31:0] d;
    logic [1:0]  r;

    gpio_axil_irq #(
        .GPIO_WIDTH  (W),
        .SYNC_STAGES (2),
        .ADDR_WIDTH  (8)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .gpio_oe       (gpio_oe),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_awready();
        int t;
        for (t = 0; t < 50 && !awready; t++) @(negedge clk);
        if (!awready) chk("awready_timeout", 32'(awready), 32'd1);
    endtask

    task automatic wait_bvalid();
        int t;
        for (t = 0; t < 50 && !bvalid; t++) @(negedge clk);
        if (!bvalid) chk("bvalid_timeout", 32'(bvalid), 32'd1);
    endtask

    task automatic wait_arready();
        int t;
        for (t = 0; t < 50 && !arready; t++) @(negedge clk);
        if (!arready) chk("arready_timeout", 32'(arready), 32'd1);
    endtask

    task automatic wait_rvalid();
        int t;
        for (t = 0; t < 50 && !rvalid; t++) @(negedge clk);
        if (!rvalid) chk("rvalid_timeout", 32'(rvalid), 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] v,
                             input logic [3:0] s, output logic [1:0] resp);
        @(negedge clk);
        awaddr  = a;
        wdata   = v;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        wait_awready();
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_bvalid();
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] v, output logic [1:0] resp);
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b0;
        wait_arready();
        @(negedge clk);
        arvalid = 1'b0;
        wait_rvalid();
        v      = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; gpio_in = '0;
        repeat (3) @(negedge clk);
        areset = 1'b0;

        // Reset state
        chk("rst_gpio_out", 32'(gpio_out), 32'd0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            axi_read(32'(i * 4), d, r);
            chk("rst_rd_data", d, 32'd0);
            chk("rst_rd_resp", 32'(r), 32'd0);
        end

        // ODR partial-strobe write, then SET and CLR
        axi_write(32'h04, 32'h0000_00F0, 4'b0001, r);
        chk("odr_wr_resp", 32'(r), 32'd0);
        axi_write(32'h0C, 32'h0000_0101, 4'b1111, r);
        chk("set_wr_resp", 32'(r), 32'd0);
        axi_read(32'h04, d, r);
        chk("odr_after_set", d, 32'h0000_01F1);

        // CLR with bready held low: next write must be blocked
        @(negedge clk);
        awaddr = 32'h10; wdata = 32'h0000_0010; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        wait_awready();
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("clr_bvalid", 32'(bvalid), 32'd1);
        awaddr = 32'h08; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_blocked", 32'(awready), 32'd0);
            chk("b_held", 32'(bvalid), 32'd1);
        end
        chk("clr_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clk);
        chk("b_drop", 32'(bvalid), 32'd0);
        chk("aw_still_low", 32'(awready), 32'd0);
        wait_awready();
        chk("wready_with_aw", 32'(wready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid();
        chk("dir_bresp", 32'(bresp), 32'd0);
        @(negedge clk);
        bready = 1'b0;

        axi_read(32'h04, d, r);
        chk("odr_final", d, 32'h0000_01E1);
        chk("gpio_out", 32'(gpio_out), 32'h0000_01E1);
        axi_read(32'h08, d, r);
        chk("dir_upper_zero", d, 32'h0000_FFFF);
        chk("gpio_oe", 32'(gpio_oe), 32'h0000_FFFF);
        axi_read(32'h0C, d, r);
        chk("set_reads_0", d, 32'd0);

        // Rising edge interrupt on pin 0
        axi_write(32'h14, 32'h0000_0001, 4'b1111, r);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(negedge clk);
        chk("irq_lat1", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lat2", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lat3", 32'(irq), 32'd1);
        axi_read(32'h00, d, r);
        chk("idr_pin0", d, 32'h0000_0001);
        axi_read(32'h1C, d, r);
        chk("isr_rise", d, 32'h0000_0001);
        axi_write(32'h1C, 32'h0000_0001, 4'b1111, r);
        chk("isr_w1c_resp", 32'(r), 32'd0);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Falling edge with FIE=0 leaves ISR clear
        gpio_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("fall_no_irq", 32'(irq), 32'd0);
        axi_read(32'h1C, d, r);
        chk("fall_isr", d, 32'd0);

        // Rising edge on pin 3 coincident with W1C of bit 3: set wins
        axi_write(32'h14, 32'h0000_0008, 4'b1111, r);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        axi_write(32'h1C, 32'h0000_0008, 4'b1111, r);
        axi_read(32'h1C, d, r);
        chk("set_wins_isr", d, 32'h0000_0008);
        chk("set_wins_irq", 32'(irq), 32'd1);
        axi_write(32'h1C, 32'h0000_0008, 4'b1111, r);
        axi_read(32'h1C, d, r);
        chk("isr3_cleared", d, 32'd0);

        // Unmapped accesses and write to read-only IDR
        axi_read(32'h40, d, r);
        chk("unmapped_rd_resp", 32'(r), 32'd2);
        chk("unmapped_rd_data", d, 32'd0);
        axi_write(32'h20, 32'hFFFF_FFFF, 4'b1111, r);
        chk("unmapped_wr_resp", 32'(r), 32'd2);
        axi_write(32'h00, 32'hFFFF_FFFF, 4'b1111, r);
        chk("idr_wr_resp", 32'(r), 32'd0);
        axi_read(32'h04, d, r);
        chk("odr_untouched", d, 32'h0000_01E1);
        axi_read(32'h14, d, r);
        chk("rie_untouched", d, 32'h0000_0008);
        axi_read(32'h1F, d, r);
        chk("low_bits_ignored", d, 32'd0);
        chk("low_bits_resp", 32'(r), 32'd0);

        // Reset while a read response is pending
        gpio_in = '0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
        wait_arready();
        @(negedge clk);
        arvalid = 1'b0;
        wait_rvalid();
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        areset = 1'b1;
        @(negedge clk);
        chk("rst_drops_rvalid", 32'(rvalid), 32'd0);
        chk("rst2_gpio_out", 32'(gpio_out), 32'd0);
        chk("rst2_gpio_oe", 32'(gpio_oe), 32'd0);
        chk("rst2_irq", 32'(irq), 32'd0);
        areset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            axi_read(32'(i * 4), d, r);
            chk("rst2_rd_data", d, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_axil_irq.md
Name: gpio_axil_irq

Overview:
Parametrised AXI4-Lite GPIO peripheral and the successor to the fixed 16-in/16-out GPIO.
- Adds per-pin direction control and atomic set/clear of outputs.
- Adds input synchronisers and per-pin rising/falling edge interrupts with a write-1-to-clear status register.
- Sits on the peripheral AXI4-Lite bus and drives one level interrupt line to the core's interrupt controller.

Parameters:
GPIO_WIDTH, 16, number of pins (1..32); register bits at and above GPIO_WIDTH read 0 and ignore writes
SYNC_STAGES, 2, flip-flop stages on gpio_in before any use (>=2)
ADDR_WIDTH, 8, AXI address bits decoded; offset = addr[ADDR_WIDTH-1:0]

Ports:
s_axi_aclk  in  1  single clock
s_axi_areset  in  1  reset, synchronous, active-high
s_axi_awaddr  in  32  write address
s_axi_awvalid/s_axi_awready  in/out  1  write address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid/s_axi_wready  in/out  1  write data handshake
s_axi_bresp  out  2  write response
s_axi_bvalid/s_axi_bready  out/in  1  write response handshake
s_axi_araddr  in  32  read address
s_axi_arvalid/s_axi_arready  in/out  1  read address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid/s_axi_rready  out/in  1  read data handshake
gpio_in  in  GPIO_WIDTH  asynchronous pin inputs
gpio_out  out  GPIO_WIDTH  output values = ODR
gpio_oe  out  GPIO_WIDTH  output enables = DIR (1 = drive)
irq  out  1  level interrupt = |ISR

Behaviour:
- Reset (synchronous, active-high): all readys, valids, resp, rdata, ODR, DIR, RIE, FIE, ISR, sync chain and previous-sample register go to 0. gpio_out, gpio_oe and irq are therefore 0.
- Register map (offsets):
  - 0x00 IDR: RO, synchronised input value.
  - 0x04 ODR: RW.
  - 0x08 DIR: RW.
  - 0x0C SET: WO; 1-bits set ODR; reads 0.
  - 0x10 CLR: WO; 1-bits clear ODR; reads 0.
  - 0x14 RIE: RW, rising-edge enable.
  - 0x18 FIE: RW, falling-edge enable.
  - 0x1C ISR: RW1C.
- Decode: addr[1:0] ignored. Any offset above 0x1C is unmapped.
- Write handshake:
  - When awvalid & wvalid & !bvalid & !awready, assert awready and wready together for exactly one cycle.
  - The register update happens in that cycle's edge.
  - bvalid rises the next cycle and holds until bready. No new write is accepted while bvalid=1.
- wstrb is honoured per byte for RW registers and for SET/CLR/ISR masks.
- Read handshake:
  - When arvalid & !rvalid & !arready, arready pulses one cycle.
  - rvalid and rdata are registered the next cycle and held stable until rready.
- Response codes:
  - Unmapped access returns SLVERR (2'b10): no state change on write, rdata=0 on read.
  - Otherwise OKAY. Writes to IDR are ignored and return OKAY.
- Synchroniser: an input change appears in IDR exactly SYNC_STAGES cycles later.
- Edge detection:
  - prev <= sync value each cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - ISR[i] sets on (rise[i]&RIE[i]) | (fall[i]&FIE[i]), one cycle after IDR changes. Detection runs regardless of DIR.
- Simultaneous ISR set and W1C on the same bit in the same cycle: set wins.
- ISR bits stay sticky until cleared. Clearing RIE/FIE does not clear ISR.
- irq is the combinational OR of the registered ISR.
- Reads and writes are independent channels and may complete in the same cycle.
- Reset mid-transaction drops all outstanding handshakes, with no response issued.

Decomposition:
- Package gpio_axil_pkg holds:
  - register offset localparams (IDR..ISR);
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the byte-strobe mask function.
- Sub-module gpio_sync_edge (GPIO_WIDTH, SYNC_STAGES) contains the synchroniser chain, prev register, and rise/fall outputs.
- The top level holds the AXI FSMs and the register file.

Test Plan:
- Reset, then read all offsets 0x00..0x1C -> every read returns 0 with OKAY; gpio_out=0, gpio_oe=0, irq=0.
- Write ODR=0x0000_00F0 with wstrb=4'b0001, then SET=0x0000_0101, then CLR=0x0000_0010 -> ODR reads 0x0000_01E1 and gpio_out matches. bvalid held for 3 cycles with bready=0 blocks the next awready.
- RIE=0x1, gpio_in[0] goes 0->1 -> IDR[0]=1 after 2 cycles, ISR=0x1 one cycle later, irq=1. W1C ISR=0x1 -> irq=0. A falling edge with FIE=0 leaves ISR=0.
- A rising edge sets ISR[3] in the same cycle a W1C of 0x8 is written -> ISR[3] remains 1.
- Read 0x40 and write 0x20 -> both return SLVERR with rdata=0, and no register changes.
- Assert reset while rvalid=1 and rready=0 -> rvalid=0 the next cycle, and all registers return to 0.
